// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the parametrised UART transmitter and receiver.
//   uart_state_t : frame sequencer states
//   PAR_*        : encodings of the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmitter.
//   clk      in  system clock
//   reset    in  asynchronous active-low reset
//   clear    in  restart a full bit period (asserted on frame acceptance)
//   bit_tick out high during the last cycle of every bit period
module uart_baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Down-counter: CLK_DIV-1 .. 0, reload on zero, so ticks are exactly CLK_DIV apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits), CLK_DIV clocks per bit.
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   start in  send request, accepted only while busy is low
//   data  in  character, captured on the accepting edge
//   tx    out serial line, idle high (registered)
//   busy  out frame in progress (registered)
//   done  out one-cycle pulse at frame end (registered)
module uart_tx_param #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  import uart_pkg::*;

  localparam int            BW        = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be at least 2");
  end

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 bit_tick;
  logic                 accept;

  assign accept = (state == IDLE) && start;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .bit_tick (bit_tick)
  );

  // Character datapath: captured on acceptance, shifted as each data bit goes out.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= data;
      par_bit <= calc_parity(data);
    end else if (bit_tick && (state == START || state == DATA)) begin
      shreg <= shreg >> 1;
    end
  end

  // Frame sequencer; bit_cnt counts data bits already placed on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_cnt <= BW'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                state <= uart_pkg::PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx      <= shreg[0];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_tick) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param across five configurations.
//   u0: CLK_DIV=4, 8 bits, even parity, 1 stop   u1: CLK_DIV=4, 7 bits, odd, 2 stop
//   u2: CLK_DIV=2, 5 bits, no parity, 1 stop     u3: CLK_DIV=5, 9 bits, odd, 2 stop
//   u4: CLK_DIV=868, 9 bits, even, 1 stop
// Expected frames are hand-written bit vectors, bit i = i-th bit on the line.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rstc;
  logic       start_a [5];
  logic       tx_a    [5];
  logic       busy_a  [5];
  logic       done_a  [5];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [4:0] d2;
  logic [8:0] d3, d4;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst0), .start(start_a[0]), .data(d0),
    .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(rstc), .start(start_a[1]), .data(d1),
    .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  uart_tx_param #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(rstc), .start(start_a[2]), .data(d2),
    .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2]));
  uart_tx_param #(.CLK_DIV(5), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(rstc), .start(start_a[3]), .data(d3),
    .tx(tx_a[3]), .busy(busy_a[3]), .done(done_a[3]));
  uart_tx_param #(.CLK_DIV(868), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u4 (
    .clk(clk), .reset(rstc), .start(start_a[4]), .data(d4),
    .tx(tx_a[4]), .busy(busy_a[4]), .done(done_a[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic s, input logic [8:0] d);
    start_a[id] = s;
    case (id)
      0:       d0 = d[7:0];
      1:       d1 = d[6:0];
      2:       d2 = d[4:0];
      3:       d3 = d;
      default: d4 = d;
    endcase
  endtask

  // Sends (or, with pre=1, continues an already accepted) frame and checks every cycle of it.
  // hold keeps start high for back-to-back operation; coll>=0 issues a second start at that cycle.
  task automatic run_frame(input string tag, input int id, input int div, input int nfb,
                           input int ndb, input logic [8:0] d, input logic [15:0] exp,
                           input bit pre, input bit hold, input int coll);
    int         ok [16];
    logic [8:0] rx;
    int         f;
    int         b;
    f  = nfb * div;
    rx = '0;
    for (int i = 0; i < 16; i++) ok[i] = 0;
    if (!pre) begin
      drive(id, 1'b1, d);
      @(posedge clk); #1;
    end
    chk($sformatf("%s accept tx", tag), 32'(tx_a[id]), 32'd0);
    chk($sformatf("%s accept busy", tag), 32'(busy_a[id]), 32'd1);
    for (int c = 0; c < f; c++) begin
      drive(id, hold || (c == coll), (coll >= 0 && c >= coll) ? 9'h1FF : d);
      b = c / div;
      if (tx_a[id] === exp[b] && busy_a[id] === 1'b1 && done_a[id] === 1'b0) ok[b]++;
      if (b >= 1 && b <= ndb && (c % div) == div / 2) rx[b-1] = tx_a[id];
      @(posedge clk); #1;
    end
    for (int i = 0; i < nfb; i++)
      chk($sformatf("%s bit%0d cycles", tag, i), 32'(ok[i]), 32'(div));
    chk($sformatf("%s decoded", tag), 32'(rx), 32'(d));
    chk($sformatf("%s end busy", tag), 32'(busy_a[id]), 32'd0);
    chk($sformatf("%s end done", tag), 32'(done_a[id]), 32'd1);
    chk($sformatf("%s end tx", tag), 32'(tx_a[id]), 32'd1);
    drive(id, hold, d);
    @(posedge clk); #1;
    chk($sformatf("%s done drop", tag), 32'(done_a[id]), 32'd0);
    chk($sformatf("%s next tx", tag), 32'(tx_a[id]), hold ? 32'd0 : 32'd1);
    chk($sformatf("%s next busy", tag), 32'(busy_a[id]), hold ? 32'd1 : 32'd0);
  endtask

  task automatic idle_check(input string tag, input int id, input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_a[id] === 1'b1 && busy_a[id] === 1'b0 && done_a[id] === 1'b0) ok++;
      @(posedge clk); #1;
    end
    chk(tag, 32'(ok), 32'(n));
  endtask

  initial begin
    rst0 = 1'b0;
    rstc = 1'b0;
    for (int i = 0; i < 5; i++) drive(i, 1'b0, 9'h000);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset tx u%0d", i), 32'(tx_a[i]), 32'd1);
      chk($sformatf("reset busy u%0d", i), 32'(busy_a[i]), 32'd0);
      chk($sformatf("reset done u%0d", i), 32'(done_a[i]), 32'd0);
    end
    #2;
    rst0 = 1'b1;
    rstc = 1'b1;
    @(posedge clk); #1;
    idle_check("idle after reset", 0, 3);

    // 8E1, A5 -> 0 10100101 0 1
    run_frame("a5", 0, 4, 11, 8, 9'h0A5, 16'h054A, 1'b0, 1'b0, -1);
    idle_check("a5 idle", 0, 3);

    // 7O2, 41 -> 0 1000001 1 11
    run_frame("41", 1, 4, 11, 7, 9'h041, 16'h0782, 1'b0, 1'b0, -1);

    // second start with FF at cycle 10 is ignored
    run_frame("3c coll", 0, 4, 11, 8, 9'h03C, 16'h0478, 1'b0, 1'b0, 10);
    idle_check("coll no second frame", 0, 20);

    // start held high: frames separated by one idle-high cycle
    run_frame("55 a", 0, 4, 11, 8, 9'h055, 16'h04AA, 1'b0, 1'b1, -1);
    run_frame("55 b", 0, 4, 11, 8, 9'h055, 16'h04AA, 1'b1, 1'b1, -1);
    run_frame("55 c", 0, 4, 11, 8, 9'h055, 16'h04AA, 1'b1, 1'b0, -1);
    idle_check("b2b idle", 0, 5);

    // asynchronous reset while bit 2 (a 0) of an A5 frame is on the line
    drive(0, 1'b1, 9'h0A5);
    @(posedge clk); #1;
    drive(0, 1'b0, 9'h0A5);
    repeat (8) @(posedge clk);
    #3;
    chk("pre-reset tx", 32'(tx_a[0]), 32'd0);
    chk("pre-reset busy", 32'(busy_a[0]), 32'd1);
    rst0 = 1'b0;
    #1;
    chk("async reset tx", 32'(tx_a[0]), 32'd1);
    chk("async reset busy", 32'(busy_a[0]), 32'd0);
    chk("async reset done", 32'(done_a[0]), 32'd0);
    repeat (3) @(posedge clk);
    #4;
    rst0 = 1'b1;
    @(posedge clk); #1;
    idle_check("post-reset idle", 0, 3);
    run_frame("81", 0, 4, 11, 8, 9'h081, 16'h0502, 1'b0, 1'b0, -1);

    // 5N1 at CLK_DIV=2: 13 -> 0 11001 1, 0A -> 0 01010 1
    run_frame("div2 13", 2, 2, 7, 5, 9'h013, 16'h0066, 1'b0, 1'b0, -1);
    run_frame("div2 0a", 2, 2, 7, 5, 9'h00A, 16'h0054, 1'b0, 1'b0, -1);
    // 9O2 at CLK_DIV=5: 1A3 -> 0 110001011 0 11
    run_frame("div5 1a3", 3, 5, 13, 9, 9'h1A3, 16'h1B46, 1'b0, 1'b0, -1);
    // 9E1 at CLK_DIV=868: 0F0 -> 0 000011110 0 1
    run_frame("div868 0f0", 4, 868, 12, 9, 9'h0F0, 16'h09E0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
